// File: rtl/hub75_rx_capture.sv
// ---------------------------------------------------------------------------
// hub75_rx_capture
//
// Purpose: sniffs a HUB75 LED-panel bus and turns each latched row pair into
// a stream of (row, col, rgb) pixels on a valid/ready interface.
//
// Handshake: pix_valid/pix_ready follow strict valid/ready semantics. A pixel
// transfers on every rising clk edge where pix_valid && pix_ready. Once
// pix_valid is high it stays high, and pix_row/pix_col/pix_rgb stay constant,
// until that transfer happens. pix_valid never depends combinationally on
// pix_ready.
//
// Parameters:
//   COLS       columns shifted per row (2..64)
//   HALF_ROWS  rows per half panel; the lower half starts at this row
//
// Ports:
//   clk, rst             system clock, synchronous active-low reset
//   r0 g0 b0 r1 g1 b1    upper/lower half colour bits (asynchronous)
//   addr[4:0]            HUB75 row address (asynchronous)
//   clk_in, latch, oe    HUB75 shift clock, latch (high), output enable (low)
//   pix_valid/pix_ready  pixel stream handshake
//   pix_row, pix_col     pixel coordinates
//   pix_rgb              {r,g,b} of the pixel
//   row_done             high in the cycle the last pixel of a row pair is taken
//   err_len, err_ovr     sticky: bad column count / latch during a drain
//   oe_active            panel currently displaying (synchronized, inverted oe)
//   stat_rows            completed row pairs (wraps at 16 bits)
//   dbg_state            current FSM state for debug and checkers
//
// Build option: define HUB75_RX_STATS_EN to enable the stat_rows counter;
// without it stat_rows is tied to zero.
// ---------------------------------------------------------------------------
module hub75_rx_capture #(
    parameter int COLS      = 64,
    parameter int HALF_ROWS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0,
    input  logic        g0,
    input  logic        b0,
    input  logic        r1,
    input  logic        g1,
    input  logic        b1,
    input  logic [4:0]  addr,
    input  logic        clk_in,
    input  logic        latch,
    input  logic        oe,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [5:0]  pix_row,
    output logic [5:0]  pix_col,
    output logic [2:0]  pix_rgb,
    output logic        row_done,
    output logic        err_len,
    output logic        err_ovr,
    output logic        oe_active,
    output logic [15:0] stat_rows,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN_TOP = 2'd1,
        DRAIN_BOT = 2'd2
    } state_e;

    localparam logic [6:0] CNT_COLS = 7'(COLS);
    localparam logic [6:0] CNT_MAX  = 7'(COLS + 1);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] HALF_OFS = 6'(HALF_ROWS);

    // ---------------- input synchronizers ----------------
    // Data bits travel through the same two stages as clk_in/latch, so they
    // are aligned with the edge that qualifies them.
    logic [13:0] sync1_q, sync2_q;
    logic        clk_prev_q, latch_prev_q;

    logic [2:0]  s_rgb_up, s_rgb_lo;
    logic [4:0]  s_addr;
    logic        s_clk, s_latch, s_oe;
    logic        clk_rise, latch_rise;

    assign s_rgb_lo   = sync2_q[2:0];
    assign s_rgb_up   = sync2_q[5:3];
    assign s_addr     = sync2_q[10:6];
    assign s_clk      = sync2_q[11];
    assign s_latch    = sync2_q[12];
    assign s_oe       = sync2_q[13];
    assign clk_rise   = s_clk & ~clk_prev_q;
    assign latch_rise = s_latch & ~latch_prev_q;

    logic oe_active_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            clk_prev_q   <= 1'b0;
            latch_prev_q <= 1'b0;
            oe_active_q  <= 1'b0;
        end else begin
            sync1_q      <= {oe, latch, clk_in, addr, r0, g0, b0, r1, g1, b1};
            sync2_q      <= sync1_q;
            clk_prev_q   <= s_clk;
            latch_prev_q <= s_latch;
            oe_active_q  <= ~s_oe;
        end
    end

    assign oe_active = oe_active_q;

    // ---------------- shift buffers and column counter ----------------
    // New bits enter at index 0 and older bits move up, so after COLS shifts
    // the first bit of the row sits at index COLS-1 and the last at index 0.
    // Buffers are sized for the largest legal COLS; only 0..COLS-1 are read.
    logic [2:0] up_q [64];
    logic [2:0] lo_q [64];
    logic [2:0] up_d [64];
    logic [2:0] lo_d [64];
    logic [6:0] col_cnt_q, col_cnt_d, cnt_shift;
    logic       count_ok;

    always_comb begin
        up_d      = up_q;
        lo_d      = lo_q;
        cnt_shift = col_cnt_q;
        if (clk_rise) begin
            for (int i = 1; i < 64; i++) begin
                up_d[i] = up_q[i-1];
                lo_d[i] = lo_q[i-1];
            end
            up_d[0] = s_rgb_up;
            lo_d[0] = s_rgb_lo;
            if (col_cnt_q != CNT_MAX) begin
                cnt_shift = col_cnt_q + 7'd1;
            end
        end
        // A shift landing in the same cycle as the latch counts toward it.
        count_ok  = (cnt_shift == CNT_COLS);
        col_cnt_d = latch_rise ? 7'd0 : cnt_shift;
    end

    always_ff @(posedge clk) begin
        up_q <= up_d;
        lo_q <= lo_d;
        if (!rst) begin
            col_cnt_q <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
        end
    end

    // ---------------- drain FSM ----------------
    state_e     state_q;
    logic [2:0] drain_up_q [64];
    logic [2:0] drain_lo_q [64];
    logic [4:0] drain_addr_q;
    logic       pix_valid_q;
    logic [5:0] pix_row_q, pix_col_q;
    logic [2:0] pix_rgb_q;
    logic       err_len_q, err_ovr_q;
    logic [5:0] col_nxt;

    assign col_nxt = pix_col_q + 6'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pix_valid_q <= 1'b0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            pix_rgb_q   <= '0;
            err_len_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            if (latch_rise) begin
                if (!count_ok) begin
                    err_len_q <= 1'b1;
                end
                if (state_q != IDLE) begin
                    // The running drain keeps its buffer; the new row is dropped.
                    err_ovr_q <= 1'b1;
                end else if (count_ok) begin
                    state_q      <= DRAIN_TOP;
                    drain_up_q   <= up_d;
                    drain_lo_q   <= lo_d;
                    drain_addr_q <= s_addr;
                    pix_valid_q  <= 1'b1;
                    pix_col_q    <= '0;
                    pix_row_q    <= {1'b0, s_addr};
                    pix_rgb_q    <= up_d[0];
                end
            end
            // pix_valid is only high outside IDLE, so this never collides
            // with the capture above.
            if (pix_valid_q && pix_ready) begin
                if (pix_col_q == LAST_COL) begin
                    if (state_q == DRAIN_TOP) begin
                        state_q   <= DRAIN_BOT;
                        pix_col_q <= '0;
                        pix_row_q <= {1'b0, drain_addr_q} + HALF_OFS;
                        pix_rgb_q <= drain_lo_q[0];
                    end else begin
                        state_q     <= IDLE;
                        pix_valid_q <= 1'b0;
                    end
                end else begin
                    pix_col_q <= col_nxt;
                    pix_rgb_q <= (state_q == DRAIN_TOP) ? drain_up_q[col_nxt]
                                                        : drain_lo_q[col_nxt];
                end
            end
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_row   = pix_row_q;
    assign pix_col   = pix_col_q;
    assign pix_rgb   = pix_rgb_q;
    assign err_len   = err_len_q;
    assign err_ovr   = err_ovr_q;
    assign dbg_state = state_q;

    // Marks the transfer itself, so it is high exactly in the cycle the final
    // lower-half pixel is handed over; a reset drops pix_valid and with it
    // any pending pulse.
    assign row_done = pix_valid_q && pix_ready && (state_q == DRAIN_BOT) &&
                      (pix_col_q == LAST_COL);

`ifdef HUB75_RX_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_q <= '0;
        end else if (row_done) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_rows = stat_q;
`else
    assign stat_rows = '0;
`endif

endmodule

// File: tb/tb_hub75_rx_capture.sv
module tb_hub75_rx_capture;

  localparam int COLS = 64;
  localparam int HALF = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic [4:0]  addr = '0;
  logic        clk_in = 0, latch = 0, oe = 0;
  logic        pix_valid, pix_ready;
  logic [5:0]  pix_row, pix_col;
  logic [2:0]  pix_rgb;
  logic        row_done, err_len, err_ovr, oe_active;
  logic [15:0] stat_rows;
  logic [1:0]  dbg_state;

  hub75_rx_capture #(.COLS(COLS), .HALF_ROWS(HALF)) dut (
    .clk(clk), .rst(rst),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_in(clk_in), .latch(latch), .oe(oe),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
    .row_done(row_done), .err_len(err_len), .err_ovr(err_ovr),
    .oe_active(oe_active), .stat_rows(stat_rows), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Expected entry: {last_of_pair, row[5:0], col[5:0], rgb[2:0]}
  logic [15:0] exp_q[$];
  logic [2:0]  tb_up[COLS];   // k-th bit shifted for the upper half
  logic [2:0]  tb_lo[COLS];
  int          rows_exp = 0;
  logic        err_len_exp = 0, err_ovr_exp = 0;

  // A latched row of n bits: bit k shifted maps to column COLS-1-k.
  task automatic model_latch(input int n, input logic [4:0] a);
    if (n != COLS) err_len_exp = 1'b1;
    if (exp_q.size() != 0) err_ovr_exp = 1'b1;
    else if (n == COLS) begin
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({1'b0, 6'(a), 6'(c), tb_up[COLS-1-c]});
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({(c == COLS-1), 6'(int'(a) + HALF), 6'(c), tb_lo[COLS-1-c]});
      rows_exp++;
    end
  endtask

  function automatic logic [15:0] stat_exp();
`ifdef HUB75_RX_STATS_EN
    return 16'(rows_exp);
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- ready driver ----------------
  // 0: always ready, 1: toggle, 2: random, 3: held low
  int   ready_mode = 0;
  logic tog = 1'b0;
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = tog;
        2: pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int          acc_cnt = 0;
  int          rd_seen = 0;
  int          valid_cycles = 0;
  logic        stall_prev = 1'b0;
  logic [14:0] prev_out;
  logic [15:0] e;

  always @(negedge clk) begin
    if (rst) begin
      if (row_done) rd_seen++;
      if (stall_prev)
        chk("stall_hold", {16'd0, pix_valid, pix_row, pix_col, pix_rgb}, {16'd0, 1'b1, prev_out});
      if (pix_valid) valid_cycles++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pix", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pix_row_col_rgb", {17'd0, pix_row, pix_col, pix_rgb}, {17'd0, e[14:0]});
          chk("row_done_at_accept", {31'd0, row_done}, {31'd0, e[15]});
          acc_cnt++;
        end
      end
      stall_prev = pix_valid && !pix_ready;
      prev_out   = {pix_row, pix_col, pix_rgb};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_row(input int n, input logic [4:0] a, input bit do_latch);
    addr = a;
    for (int k = 0; k < n; k++) begin
      {r0, g0, b0} = tb_up[k];
      {r1, g1, b1} = tb_lo[k];
      cycles(3);
      clk_in = 1'b1;
      cycles(3);
      clk_in = 1'b0;
    end
    if (do_latch) begin
      cycles(3);
      latch = 1'b1;
      model_latch(n, a);
      cycles(3);
      latch = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < COLS; k++) begin
      tb_up[k] = 3'($urandom_range(0, 7));
      tb_lo[k] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic fill_const(input logic [2:0] u, input logic [2:0] l);
    for (int k = 0; k < COLS; k++) begin
      tb_up[k] = u;
      tb_lo[k] = l;
    end
  endtask

  task automatic wait_drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    cycles(3);
    chk({tag, "_idle_valid"}, {31'd0, pix_valid}, 32'd0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_err_len"}, {31'd0, err_len}, {31'd0, err_len_exp});
    chk({tag, "_err_ovr"}, {31'd0, err_ovr}, {31'd0, err_ovr_exp});
    chk({tag, "_row_done_cnt"}, 32'(rd_seen), 32'(rows_exp));
    chk({tag, "_stat_rows"}, {16'd0, stat_rows}, {16'd0, stat_exp()});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycles(3);
    exp_q.delete();
    rows_exp = 0; rd_seen = 0; acc_cnt = 0;
    err_len_exp = 0; err_ovr_exp = 0;
    rst = 1'b1;
    cycles(2);
  endtask

  // ---------------- main sequence ----------------
  int i;
  initial begin
    // reset state
    rst = 1'b0;
    cycles(4);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_row_done", {31'd0, row_done}, 32'd0);
    chk("rst_err_len", {31'd0, err_len}, 32'd0);
    chk("rst_err_ovr", {31'd0, err_ovr}, 32'd0);
    chk("rst_oe_active", {31'd0, oe_active}, 32'd0);
    chk("rst_stat_rows", {16'd0, stat_rows}, 32'd0);
    chk("rst_pix_coords", {17'd0, pix_row, pix_col, pix_rgb}, 32'd0);
    rst = 1'b1;
    cycles(2);

    // output-enable status follows the inverted, synchronized oe
    oe = 1'b0; cycles(5);
    chk("oe_active_on", {31'd0, oe_active}, 32'd1);
    oe = 1'b1; cycles(5);
    chk("oe_active_off", {31'd0, oe_active}, 32'd0);
    oe = 1'b0;

    // single red dot: first bit shifted lands at column COLS-1
    fill_const(3'b000, 3'b000);
    tb_up[0] = 3'b100;
    ready_mode = 0; acc_cnt = 0;
    send_row(COLS, 5'd5, 1'b1);
    wait_drain("dot");
    chk("dot_pix_count", 32'(acc_cnt), 32'(2*COLS));
    check_status("dot");

    // lower half row numbering
    fill_const(3'b000, 3'b010);
    send_row(COLS, 5'd31, 1'b1);
    wait_drain("lower");
    check_status("lower");

    // back-pressure with alternating ready
    fill_random();
    ready_mode = 1; valid_cycles = 0; acc_cnt = 0;
    send_row(COLS, 5'($urandom_range(0, 31)), 1'b1);
    wait_drain("bp");
    chk("bp_pix_count", 32'(acc_cnt), 32'(2*COLS));
    chk("bp_cycle_count", {31'd0, (valid_cycles == 4*COLS || valid_cycles == 4*COLS-1)}, 32'd1);

    // random rows with random back-pressure
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      send_row(COLS, 5'($urandom_range(0, 31)), 1'b1);
      wait_drain("rand");
    end
    check_status("rand");

    // short row: length error, nothing emitted
    fill_random();
    ready_mode = 0; acc_cnt = 0;
    send_row(COLS-1, 5'd7, 1'b1);
    cycles(30);
    chk("len_err_no_pix", 32'(acc_cnt), 32'd0);
    check_status("len");

    // overrun: second row latched while first is stalled
    ready_mode = 3; acc_cnt = 0;
    fill_random();
    send_row(COLS, 5'd9, 1'b1);
    fill_random();
    send_row(COLS, 5'd10, 1'b1);
    cycles(5);
    chk("ovr_err_flag", {31'd0, err_ovr}, 32'd1);
    chk("ovr_still_valid", {31'd0, pix_valid}, 32'd1);
    ready_mode = 0;
    wait_drain("ovr");
    chk("ovr_pix_count", 32'(acc_cnt), 32'(2*COLS));
    check_status("ovr");

    // reset in the middle of a drain
    do_reset();
    fill_random();
    ready_mode = 0; acc_cnt = 0;
    send_row(COLS, 5'd3, 1'b1);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (acc_cnt >= 10) break;
    end
    chk("mid_reset_reached", 32'(acc_cnt), 32'd10);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", {31'd0, pix_valid}, 32'd0);
    chk("mid_reset_row_done", {31'd0, row_done}, 32'd0);
    cycles(2);
    chk("mid_reset_row_done_cnt", 32'(rd_seen), 32'd0);
    chk("mid_reset_pix_count", 32'(acc_cnt), 32'd10);
    exp_q.delete();
    rows_exp = 0; rd_seen = 0; acc_cnt = 0;
    err_len_exp = 0; err_ovr_exp = 0;
    rst = 1'b1;
    cycles(2);
    check_status("after_reset");

    // partially shifted row is lost across reset
    fill_random();
    send_row(20, 5'd2, 1'b0);
    do_reset();
    fill_random();
    send_row(COLS, 5'd12, 1'b1);
    wait_drain("partial");
    check_status("partial");

    // three full rows for the statistics counter
    do_reset();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      send_row(COLS, 5'($urandom_range(0, 31)), 1'b1);
      wait_drain("stats");
    end
    check_status("stats");

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
